fp32_to_int32_iter: RTL and testbench

//  Multi-cycle converter from FP32 (1 sign, 8 exp biased by 127, 23 mantissa) to signed INT32.
//  It is the decode direction of our FP32 datapath: it reads the format that the adder produces.
//  It sits between the FP unit result path and integer consumers.

---
 rtl/fp32_to_int32_iter.sv | 156 +++++++++++++++
 tb/tb_fp32_to_int32_iter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_iter.sv
// fp32_to_int32_iter: multi-cycle FP32 -> signed INT32 converter.
// The significand is aligned by an iterative shifter moving up to STEP bits
// per cycle. The result is truncated toward zero and saturated on overflow.
// Input and output each use a valid/ready handshake, and only one operation
// is in flight at a time.
module fp32_to_int32_iter #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_nv
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    HOLD
  } state_t;

  localparam logic [4:0]  STEP_W    = 5'(STEP);
  localparam logic [31:0] INT_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] NEG_2P31  = 32'hCF00_0000;
  localparam logic [7:0]  EXP_ONE   = 8'd127;
  localparam logic [7:0]  EXP_ALIGN = 8'd150;
  localparam logic [7:0]  EXP_SAT   = 8'd158;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  count;
  logic        dir_left;
  logic        sign;
  logic        ovf_pend;
  logic        nv_pend;

  // Operand fields
  logic [7:0]  exp_in;
  logic [22:0] mant_in;

  // Values loaded on accept
  logic [31:0] ld_work;
  logic [4:0]  ld_count;
  logic        ld_left;
  logic        ld_sign;
  logic        ld_ovf;
  logic        ld_nv;

  // Per-cycle shift amount
  logic [4:0]  shift_amt;

  assign exp_in   = in_data[30:23];
  assign mant_in  = in_data[22:0];
  assign in_ready = (state == IDLE);

  // Decode the incoming operand. Special cases preload the final value with
  // the sign cleared, so FINISH passes it through without negation.
  always_comb begin
    ld_work  = {8'b0, 1'b1, mant_in};
    ld_count = '0;
    ld_left  = 1'b0;
    ld_sign  = in_data[31];
    ld_ovf   = 1'b0;
    ld_nv    = 1'b0;
    if (exp_in == 8'hFF && mant_in != '0) begin
      ld_work = INT_MAX;
      ld_sign = 1'b0;
      ld_nv   = 1'b1;
    end else if (exp_in < EXP_ONE) begin
      ld_work = '0;
      ld_sign = 1'b0;
    end else if (in_data == NEG_2P31) begin
      ld_work = INT_MIN;
      ld_sign = 1'b0;
    end else if (exp_in >= EXP_SAT) begin
      ld_work = in_data[31] ? INT_MIN : INT_MAX;
      ld_sign = 1'b0;
      ld_ovf  = 1'b1;
    end else if (exp_in >= EXP_ALIGN) begin
      ld_count = 5'(exp_in - EXP_ALIGN);
      ld_left  = 1'b1;
    end else begin
      ld_count = 5'(EXP_ALIGN - exp_in);
      ld_left  = 1'b0;
    end
  end

  // Shift by STEP bits, or by whatever remains if that is fewer.
  always_comb begin
    shift_amt = (count < STEP_W) ? count : STEP_W;
  end

  // Converter FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      dir_left  <= 1'b0;
      sign      <= 1'b0;
      ovf_pend  <= 1'b0;
      nv_pend   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
      out_nv    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= ld_work;
            count    <= ld_count;
            dir_left <= ld_left;
            sign     <= ld_sign;
            ovf_pend <= ld_ovf;
            nv_pend  <= ld_nv;
            state    <= (ld_count != '0) ? SHIFT : FINISH;
          end
        end
        SHIFT: begin
          if (dir_left) begin
            work <= work << shift_amt;
          end else begin
            work <= work >> shift_amt;
          end
          count <= count - shift_amt;
          if (count == shift_amt) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          out_data  <= sign ? (-work) : work;
          out_ovf   <= ovf_pend;
          out_nv    <= nv_pend;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_iter.sv
// Testbench for fp32_to_int32_iter.
// Drivers change inputs 1 time unit after a rising edge, and the monitor
// samples on falling edges. Each accepted operand pushes its expected
// result, flags, latency and accept edge onto a scoreboard queue. The
// monitor checks latency when out_valid rises and checks data and flags
// on the output handshake.
module tb_fp32_to_int32_iter;

  localparam int STEP = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_nv;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        nv;
    int          lat;
    int          k;
    logic [31:0] op;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  fp32_to_int32_iter #(.STEP(STEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_nv    (out_nv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written directly from the number format
  function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                output logic ovf, output logic nv, output int lat);
    int e;
    logic [63:0] mag;
    e   = int'(x[30:23]);
    r   = '0;
    ovf = 1'b0;
    nv  = 1'b0;
    lat = 1;
    if (e == 255 && x[22:0] != 23'd0) begin
      r  = 32'h7FFF_FFFF;
      nv = 1'b1;
    end else if (e >= 127) begin
      mag = {40'd0, 1'b1, x[22:0]};
      if (e >= 180)      mag = 64'hFFFF_FFFF_FFFF;
      else if (e >= 150) mag = mag << (e - 150);
      else               mag = mag >> (150 - e);
      if (e <= 157) lat = 1 + (((e >= 150) ? e - 150 : 150 - e) + STEP - 1) / STEP;
      if (x[31] && mag == 64'h8000_0000) begin
        r = 32'h8000_0000;
      end else if (mag >= 64'h8000_0000) begin
        ovf = 1'b1;
        r   = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        r = x[31] ? 32'(-mag) : 32'(mag);
      end
    end
  endfunction

  task automatic edge_counter();
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  endtask

  task automatic monitor();
    logic        prev_valid;
    logic [31:0] prev_data;
    exp_t        x;
    int          lat;
    prev_valid = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: out_data=%h with no operand pending, required none", out_data);
          end else begin
            lat = edge_cnt - sb[0].k;
            if (lat !== sb[0].lat) begin
              n_fail++;
              $display("FAIL latency op=%h: got k+%0d, required k+%0d", sb[0].op, lat, sb[0].lat);
            end
          end
        end
        if (out_valid && prev_valid) begin
          n_checks++;
          if (out_data !== prev_data) begin
            n_fail++;
            $display("FAIL hold_stable: out_data=%h, required %h", out_data, prev_data);
          end
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          x = sb.pop_front();
          n_checks++;
          if (out_data !== x.data || out_ovf !== x.ovf || out_nv !== x.nv) begin
            n_fail++;
            $display("FAIL result op=%h: got %h ovf=%b nv=%b, required %h ovf=%b nv=%b",
                     x.op, out_data, out_ovf, out_nv, x.data, x.ovf, x.nv);
          end
        end
        prev_valid = out_valid;
        prev_data  = out_data;
      end
    end
  endtask

  // Offer one operand, wait for it to be accepted, and record its expectation
  task automatic send(input logic [31:0] d, input logic [31:0] ed, input logic eo,
                      input logic en, input int el);
    int t;
    exp_t x;
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout op=%h: in_ready=0, required 1", d);
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    x.data = ed; x.ovf = eo; x.nv = en; x.lat = el; x.k = edge_cnt + 1; x.op = d;
    sb.push_back(x);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] d);
    logic [31:0] r;
    logic o, n;
    int l;
    model(d, r, o, n, l);
    send(d, r, o, n, l);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #1 t++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    n_checks++;
    if (out_ovf !== 1'b0 || out_nv !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ovf=%b nv=%b, required 0 0", out_ovf, out_nv);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] ops [12];
    logic [31:0] res [12];
    logic [1:0]  flg [12];
    int          lats[12];
    ops = '{32'h3F800000, 32'hC2F6E979, 32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hFF800000,
            32'h7FC00000, 32'h3F000000, 32'h80000000, 32'h4B000000, 32'hCEFFFFFF, 32'hBF000000};
    res = '{32'h00000001, 32'hFFFFFF85, 32'h7FFFFF80, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
            32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h00800000, 32'h80000080, 32'h00000000};
    // flags as {ovf, nv}
    flg = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10,
            2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    lats = '{7, 6, 3, 1, 1, 1, 1, 1, 1, 1, 3, 1};
    for (int i = 0; i < 12; i++) begin
      send(ops[i], res[i], flg[i][1], flg[i][0], lats[i]);
      drain();
    end
  endtask

  task automatic test_backpressure();
    int t;
    out_ready = 1'b0;
    send(32'h3F800000, 32'h00000001, 1'b0, 1'b0, 7);
    fork
      send(32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b0, 6);
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        n_checks++;
        if (!out_valid) begin
          n_fail++; $display("FAIL bp_valid_timeout: out_valid=0, required 1");
        end
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (in_ready !== 1'b0 || out_data !== 32'h00000001 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b out_data=%h, required 0 1 00000001",
                     in_ready, out_valid, out_data);
          end
        end
        n_checks++;
        if (sb.size() != 1) begin
          n_fail++; $display("FAIL bp_no_accept: %0d pending, required 1", sb.size());
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_mid();
    send(32'h3F800000, 32'h00000001, 1'b0, 1'b0, 7);
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b out_data=%h, required 0 1 00000000",
               out_valid, in_ready, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b0, 6);
    drain();
  endtask

  task automatic test_back_to_back();
    bit stop;
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] e;
          int r;
          r = $urandom_range(0, 9);
          if (r == 0)      e = 8'hFF;
          else if (r == 1) e = 8'($urandom_range(0, 126));
          else             e = 8'($urandom_range(127, 160));
          send_model({1'($urandom_range(0, 1)), e, 23'($urandom)});
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    fork
      edge_counter();
      monitor();
    join_none
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
